// File: rtl/line_buffer_sequencer.sv
// Write/read sequencer for six rotating line buffers feeding a stereo block-matching window.
// Steers each pixel to the current buffer, rotates at end of line and flags when five lines are buffered.
module line_buffer_sequencer #(
  parameter int LINE_WIDTH  = 320,
  parameter int FRAME_LINES = 240,
  parameter int AW          = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pixel_valid,
  output logic [5:0]    write_enable,
  output logic [AW-1:0] write_addr,
  output logic [AW-1:0] read_addr,
  output logic [2:0]    read_select,
  output logic          window_valid,
  output logic          line_done,
  output logic          frame_done
);

  localparam int LNW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t         state_p0, state_nx;
  logic [2:0]     wr_idx_p0, wr_idx_nx;
  logic [AW-1:0]  col_p0, col_nx;
  logic [LNW-1:0] line_p0, line_nx;
  logic [2:0]     filled_p0, filled_nx;
  logic           line_done_p1, frame_done_p1;
  logic           ld_nx, fd_nx;

  logic [2:0] widx;
  logic [2:0] sel;
  logic       active;
  logic       accept;
  logic       eol;
  logic       eof;
  logic [2:0] filled_inc;

  // Buffer indices 6 and 7 cannot occur; map them back to buffer 0.
  function automatic logic [2:0] safe_idx(input logic [2:0] i);
    return (i > 3'd5) ? 3'd0 : i;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i >= 3'd5) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] f);
    return (f >= 3'd5) ? 3'd5 : f + 3'd1;
  endfunction

  always_comb begin
    widx       = safe_idx(wr_idx_p0);
    active     = (state_p0 != IDLE);
    accept     = pixel_valid && (active || frame_start);
    eol        = active && !frame_start && pixel_valid && (col_p0 == AW'(LINE_WIDTH - 1));
    eof        = eol && (line_p0 == LNW'(FRAME_LINES - 1));
    filled_inc = sat_inc(filled_p0);
    // A coinciding frame_start redirects this pixel to column 0 of buffer 0.
    sel          = frame_start ? 3'd0 : widx;
    write_enable = accept ? (6'b000001 << sel) : 6'b000000;
    write_addr   = frame_start ? '0 : col_p0;
    read_addr    = write_addr;
    read_select  = sel;
    window_valid = pixel_valid && (state_p0 == STREAM) && !frame_start;
  end

  always_comb begin
    state_nx  = state_p0;
    wr_idx_nx = widx;
    col_nx    = col_p0;
    line_nx   = line_p0;
    filled_nx = filled_p0;
    ld_nx     = 1'b0;
    fd_nx     = 1'b0;
    if (frame_start) begin
      state_nx  = FILL;
      wr_idx_nx = 3'd0;
      col_nx    = pixel_valid ? AW'(1) : '0;
      line_nx   = '0;
      filled_nx = 3'd0;
    end else if (active && pixel_valid) begin
      if (eol) begin
        col_nx = '0;
        ld_nx  = 1'b1;
        if (eof) begin
          state_nx  = IDLE;
          wr_idx_nx = 3'd0;
          line_nx   = '0;
          filled_nx = 3'd0;
          fd_nx     = 1'b1;
        end else begin
          wr_idx_nx = next_idx(widx);
          line_nx   = line_p0 + LNW'(1);
          filled_nx = filled_inc;
          if (state_p0 == FILL && filled_inc == 3'd5) begin
            state_nx = STREAM;
          end
        end
      end else begin
        col_nx = col_p0 + AW'(1);
      end
    end
  end

  // Stage p0 -> p1: counter state and end-of-line/frame pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0      <= IDLE;
      wr_idx_p0     <= 3'd0;
      col_p0        <= '0;
      line_p0       <= '0;
      filled_p0     <= 3'd0;
      line_done_p1  <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      state_p0      <= state_nx;
      wr_idx_p0     <= wr_idx_nx;
      col_p0        <= col_nx;
      line_p0       <= line_nx;
      filled_p0     <= filled_nx;
      line_done_p1  <= ld_nx;
      frame_done_p1 <= fd_nx;
    end
  end

  assign line_done  = line_done_p1;
  assign frame_done = frame_done_p1;

endmodule
